// File: rtl/inst_fetch_aligner.sv
// Fetch aligner: turns word-wide imem reads into whole RV32IC instructions at any halfword PC.
// Optional ALIGN_ILLEGAL_CHK_EN adds o_inst_illegal, flagging the all-zero compressed encoding.
module inst_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_valid,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_id_ready,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_c_inst_flag
`ifdef ALIGN_ILLEGAL_CHK_EN
  ,
  output logic        o_inst_illegal
`endif
);

  logic [15:0] r_q_data [3];
  logic [31:0] r_q_pc   [3];
  logic [1:0]  r_count;
  logic [31:0] r_fetch_addr;
  logic        r_outstanding;
  logic        r_drop_resp;
  logic        r_skip_lo;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_c_flag;

  logic [15:0] w_q_data_nxt [3];
  logic [31:0] w_q_pc_nxt   [3];
  logic [1:0]  w_count_nxt;
  logic [1:0]  w_pop_n;
  logic [1:0]  w_base;
  logic        w_head_c;
  logic        w_inst_valid;
  logic [31:0] w_inst_cur;
  logic        w_req;
  logic        w_resp;
  logic        w_push;
  logic [31:0] w_resp_addr;

  assign w_head_c     = (r_q_data[0][1:0] != 2'b11);
  assign w_inst_valid = ((r_count != 2'd0) && w_head_c) || ((r_count >= 2'd2) && !w_head_c);
  assign w_inst_cur   = w_head_c ? {16'h0000, r_q_data[0]} : {r_q_data[1], r_q_data[0]};
  assign w_pop_n      = (w_inst_valid && i_id_ready) ? (w_head_c ? 2'd1 : 2'd2) : 2'd0;
  assign w_req        = (r_count <= 2'd1) && !r_outstanding && i_rst_n && !i_redirect;
  // Only a response to our own outstanding request is honoured.
  assign w_resp       = i_imem_valid && r_outstanding;
  assign w_push       = w_resp && !r_drop_resp && !i_redirect;
  // fetch_addr was advanced when the request issued, so the returning word is one behind.
  assign w_resp_addr  = r_fetch_addr - 32'd4;
  assign w_base       = r_count - w_pop_n;

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_fetch_addr;
  assign o_inst_valid  = w_inst_valid;
  assign o_inst        = w_inst_valid ? w_inst_cur : r_inst;
  assign o_inst_pc     = w_inst_valid ? r_q_pc[0] : r_inst_pc;
  assign o_c_inst_flag = w_inst_valid ? w_head_c : r_c_flag;
`ifdef ALIGN_ILLEGAL_CHK_EN
  assign o_inst_illegal = w_inst_valid && w_head_c && (r_q_data[0] == 16'h0000);
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_q_data_nxt[i] = r_q_data[i];
      w_q_pc_nxt[i]   = r_q_pc[i];
    end
    w_count_nxt = w_base;
    unique case (w_pop_n)
      2'd1: begin
        w_q_data_nxt[0] = r_q_data[1];
        w_q_pc_nxt[0]   = r_q_pc[1];
        w_q_data_nxt[1] = r_q_data[2];
        w_q_pc_nxt[1]   = r_q_pc[2];
      end
      2'd2: begin
        w_q_data_nxt[0] = r_q_data[2];
        w_q_pc_nxt[0]   = r_q_pc[2];
      end
      default: ;
    endcase
    // Request only issues at count<=1, so base<=1 and both halves always fit.
    if (w_push) begin
      if (r_skip_lo) begin
        w_q_data_nxt[w_base] = i_imem_rdata[31:16];
        w_q_pc_nxt[w_base]   = w_resp_addr + 32'd2;
        w_count_nxt          = w_base + 2'd1;
      end else begin
        w_q_data_nxt[w_base]        = i_imem_rdata[15:0];
        w_q_pc_nxt[w_base]          = w_resp_addr;
        w_q_data_nxt[w_base + 2'd1] = i_imem_rdata[31:16];
        w_q_pc_nxt[w_base + 2'd1]   = w_resp_addr + 32'd2;
        w_count_nxt                 = w_base + 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_q_data[i] <= 16'h0000;
        r_q_pc[i]   <= 32'h0;
      end
      r_count       <= 2'd0;
      r_fetch_addr  <= {RESET_PC[31:2], 2'b00};
      r_outstanding <= 1'b0;
      r_drop_resp   <= 1'b0;
      r_skip_lo     <= RESET_PC[1];
      r_inst        <= 32'h0;
      r_inst_pc     <= 32'h0;
      r_c_flag      <= 1'b0;
    end else begin
      if (w_inst_valid) begin
        r_inst    <= w_inst_cur;
        r_inst_pc <= r_q_pc[0];
        r_c_flag  <= w_head_c;
      end
      if (i_redirect) begin
        r_count      <= 2'd0;
        r_fetch_addr <= {i_redirect_pc[31:2], 2'b00};
        r_skip_lo    <= i_redirect_pc[1];
        if (r_outstanding) begin
          if (i_imem_valid) begin
            r_outstanding <= 1'b0;
            r_drop_resp   <= 1'b0;
          end else begin
            r_drop_resp <= 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          r_q_data[i] <= w_q_data_nxt[i];
          r_q_pc[i]   <= w_q_pc_nxt[i];
        end
        r_count <= w_count_nxt;
        if (w_resp) begin
          r_outstanding <= 1'b0;
          r_drop_resp   <= 1'b0;
          if (w_push) r_skip_lo <= 1'b0;
        end
        if (w_req) begin
          r_outstanding <= 1'b1;
          r_fetch_addr  <= r_fetch_addr + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_aligner.sv
// Scoreboard bench for inst_fetch_aligner: directed memory images, expected issues queued up front.
module tb_inst_fetch_aligner;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_imem_valid;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_id_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_c_inst_flag;
`ifdef ALIGN_ILLEGAL_CHK_EN
  logic        o_inst_illegal;
  localparam logic ILL0 = 1'b1;
`else
  localparam logic ILL0 = 1'b0;
`endif

  always #5 clk = ~clk;

  inst_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .i_imem_valid  (i_imem_valid),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_id_ready    (i_id_ready),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_c_inst_flag (o_c_inst_flag)
`ifdef ALIGN_ILLEGAL_CHK_EN
    ,
    .o_inst_illegal(o_inst_illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] req_log[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [0:127];
  bit          ok  [0:127];
  int          lat = 1;
  bit          pend;
  logic [31:0] paddr;
  int          cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Memory model: words with ok=0 are never answered (bus stalls forever).
  initial begin
    pend = 1'b0;
    i_imem_valid = 1'b0;
    i_imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      i_imem_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          pend = 1'b0;
          if (paddr < 32'd512 && ok[paddr[8:2]]) begin
            i_imem_valid = 1'b1;
            i_imem_rdata = mem[paddr[8:2]];
          end
        end else begin
          cnt--;
        end
      end
      @(negedge clk);
      if (!i_rst_n) begin
        pend = 1'b0;
      end else if (o_imem_req) begin
        pend  = 1'b1;
        paddr = o_imem_addr;
        cnt   = lat;
        req_log.push_back(o_imem_addr);
      end
    end
  end

  // Monitor: every accepted instruction is matched against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst_n === 1'b1 && o_inst_valid && i_id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got inst %h pc %h, expected no issue", o_inst, o_inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_inst", o_inst, e.inst);
          check("issue_pc", o_inst_pc, e.pc);
          check("issue_cflag", {31'b0, o_c_inst_flag}, {31'b0, e.c});
`ifdef ALIGN_ILLEGAL_CHK_EN
          check("issue_illegal", {31'b0, o_inst_illegal}, {31'b0, e.ill});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'h0;
      ok[i]  = 1'b0;
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ok[idx]  = 1'b1;
  endtask

  task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc, input logic c,
                             input logic ill);
    exp_t x;
    x.inst = inst;
    x.pc   = pc;
    x.c    = c;
    x.ill  = ill;
    exp_q.push_back(x);
  endtask

  task automatic reset_dut();
    i_rst_n       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_id_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("req_in_reset", {31'b0, o_imem_req}, 32'd0);
    check("valid_in_reset", {31'b0, o_inst_valid}, 32'd0);
    @(posedge clk);
    #1;
    req_log.delete();
    i_rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
    check("drain_remaining", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_req(input string name, input int idx, input logic [31:0] addr);
    checks++;
    if (req_log.size() <= idx) begin
      errors++;
      $display("FAIL %s: got %0d requests, expected request %0d at %h", name, req_log.size(), idx,
               addr);
    end else if (req_log[idx] !== addr) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, req_log[idx], addr);
    end
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_id_ready    = 1'b0;

    // 32-bit addi at PC 0, then the next word address goes out.
    clear_mem();
    lat = 1;
    set_word(0, 32'h0013_0513);
    expect_inst(32'h0013_0513, 32'h0, 1'b0, 1'b0);
    reset_dut();
    @(negedge clk);
    check("rst_inst", o_inst, 32'h0);
    check("rst_inst_pc", o_inst_pc, 32'h0);
    check("rst_cflag", {31'b0, o_c_inst_flag}, 32'd0);
    check("rst_valid", {31'b0, o_inst_valid}, 32'd0);
    drain(20);
    check_req("t1_req0", 0, 32'h0);
    check_req("t1_req1", 1, 32'h4);

    // Two compressed instructions in one word.
    clear_mem();
    set_word(0, 32'h4505_0505);
    expect_inst(32'h0000_0505, 32'h0, 1'b1, 1'b0);
    expect_inst(32'h0000_4505, 32'h2, 1'b1, 1'b0);
    reset_dut();
    drain(20);

    // Straddling 32-bit instruction at PC 2, slower memory.
    clear_mem();
    lat = 2;
    set_word(0, 32'h0513_0001);
    set_word(1, 32'h1111_0013);
    expect_inst(32'h0000_0001, 32'h0, 1'b1, 1'b0);
    expect_inst(32'h0013_0513, 32'h2, 1'b0, 1'b0);
    expect_inst(32'h0000_1111, 32'h6, 1'b1, 1'b0);
    reset_dut();
    drain(30);
    check_req("t3_req1", 1, 32'h4);

    // Redirect to 0x102 while the word-0 request is in flight.
    clear_mem();
    lat = 3;
    set_word(0, 32'h4501_4501);
    set_word(64, 32'h0001_0513);
    expect_inst(32'h0000_0001, 32'h102, 1'b1, 1'b0);
    reset_dut();
    for (int k = 0; k < 20 && req_log.size() == 0; k++) @(negedge clk);
    check_req("t4_req0", 0, 32'h0);
    @(posedge clk);
    #1;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0102;
    @(posedge clk);
    #1;
    i_redirect = 1'b0;
    @(negedge clk);
    check("t4_valid_after_redirect", {31'b0, o_inst_valid}, 32'd0);
    drain(30);
    check_req("t4_req_redirect", 1, 32'h100);

    // Stall: output held, queue full enough to block requests.
    clear_mem();
    lat = 1;
    set_word(0, 32'h0013_0513);
    set_word(1, 32'h0001_0001);
    expect_inst(32'h0013_0513, 32'h0, 1'b0, 1'b0);
    expect_inst(32'h0000_0001, 32'h4, 1'b1, 1'b0);
    expect_inst(32'h0000_0001, 32'h6, 1'b1, 1'b0);
    reset_dut();
    i_id_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, o_inst_valid}, 32'd1);
      check("stall_inst", o_inst, 32'h0013_0513);
      check("stall_pc", o_inst_pc, 32'h0);
      check("stall_no_req", {31'b0, o_imem_req}, 32'd0);
    end
    check("stall_req_count", req_log.size(), 32'd1);
    @(posedge clk);
    #1;
    i_id_ready = 1'b1;
    drain(20);
    check_req("t5_req1", 1, 32'h4);

    // All-zero word: two defined-illegal compressed encodings.
    clear_mem();
    set_word(0, 32'h0000_0000);
    expect_inst(32'h0, 32'h0, 1'b1, ILL0);
    expect_inst(32'h0, 32'h2, 1'b1, ILL0);
    reset_dut();
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_aligner.md
Name: inst_fetch_aligner

Overview:
- Fetch-side stage of the RV32IC single-cycle core, sitting between word-wide instruction memory and the decode/controller path.
- Fetches aligned 32-bit words and keeps a halfword queue, so that 16-bit compressed and 32-bit instructions at any halfword address (including word-straddling ones) are delivered whole.
- Each delivered instruction carries c_inst_flag and its PC; these feed the decoder and the next-PC select (PC+2 vs PC+4).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; must be halfword aligned, bit 0 ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- imem_req  out  1  word read request; one cycle per request.
- imem_addr  out  32  word address ({addr[31:2],2'b00}); valid while imem_req=1.
- imem_rdata  in  32  returned word; little-endian, halfword 0 = bits[15:0].
- imem_valid  in  1  imem_rdata valid; in order, latency >=1 cycle.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  redirect target; bit 0 ignored.
- id_ready  in  1  decode accepts the presented instruction this cycle.
- inst_valid  out  1  inst/inst_pc/c_inst_flag valid.
- inst  out  32  instruction; a compressed instruction is zero-extended {16'h0,hw}.
- inst_pc  out  32  PC of inst.
- c_inst_flag  out  1  1 when inst[1:0]!=2'b11.

Behaviour:
- State: 3-entry halfword queue (data + PC per entry, count 0..3), fetch_addr, outstanding flag (max 1 request in flight), drop_resp flag, skip_lo flag.
- Reset (rst_n=0 at edge): count=0, outstanding=0, drop_resp=0, fetch_addr={RESET_PC[31:2],2'b00}, skip_lo=RESET_PC[1]. All outputs 0.
- Request rule: imem_req=1 when count<=1, outstanding=0, rst_n=1 and redirect=0. On that edge: outstanding=1, fetch_addr+=4 (wraps mod 2^32).
- Response handling when imem_valid=1:
  - drop_resp=1: discard the word and clear drop_resp and outstanding.
  - otherwise: push both halfwords (PCs addr, addr+2), or only the upper halfword if skip_lo=1 (then clear skip_lo); clear outstanding.
  - Room is guaranteed because count<=1 at request time.
- Issue logic (combinational from the queue head):
  - head[1:0]!=2'b11 and count>=1: inst_valid=1, inst={16'h0,head}, c_inst_flag=1, pop 1.
  - head[1:0]==2'b11 and count>=2: inst_valid=1, inst={q1,head}, c_inst_flag=0, pop 2.
  - otherwise inst_valid=0; inst/inst_pc/c_inst_flag hold their last value.
  - inst_pc = head PC.
  - Pop occurs only when inst_valid && id_ready. Push and pop in the same cycle are both applied.
- Latency: a word accepted at edge N produces inst_valid=1 after edge N (combinational from the queue).
- Stall: while inst_valid=1 and id_ready=0, outputs are held stable and the queue is unchanged.
- Redirect (wins over imem_valid, pops, and requests in the same cycle):
  - count=0, fetch_addr={redirect_pc[31:2],2'b00}, skip_lo=redirect_pc[1].
  - If a request is outstanding and no response arrives this cycle: drop_resp=1.
  - If the response arrives this same cycle: it is discarded and outstanding cleared.
  - inst_valid=0 in the cycle after redirect; the new request goes out no earlier than the next cycle.
- Straddle: a 32-bit instruction at PC[1]=1 waits with count=1 until the next word arrives.
- Reset mid-operation clears everything as above; any response to a pre-reset request is ignored (outstanding=0, imem_valid not honoured until after a post-reset request).

Optional Feature:
- ALIGN_ILLEGAL_CHK_EN defined:
  - Adds output inst_illegal (1 bit).
  - =1 together with inst_valid when the issued instruction is compressed and the head halfword == 16'h0000 (defined-illegal RVC encoding). Otherwise 0; reset 0.
- Not defined: port absent; 16'h0000 is delivered as an ordinary compressed instruction.

Test Plan:
- Reset RESET_PC=0; memory word0=32'h0013_0513 (addi) with id_ready=1 -> inst=32'h0013_0513, inst_pc=0, c_inst_flag=0, then request addr 4.
- word0=32'h4505_0505 -> two issues: inst=32'h0000_0505 at pc 0, then 32'h0000_4505 at pc 2, both with c_inst_flag=1.
- Straddle: word0=32'h0513_0001, word1=32'h1111_0013 -> c.nop at pc 0, then inst=32'h0013_0513 at pc 2 only after word1 returns.
- redirect_pc=32'h0000_0102 while a request is outstanding -> in-flight word dropped; next request addr 0x100; lower half skipped; first inst_pc=0x102.
- Hold id_ready=0 for 5 cycles with inst_valid=1 -> inst/inst_pc stable; no more than 3 halfwords queued; no request while count>=2.
- With ALIGN_ILLEGAL_CHK_EN: word0=32'h0000_0000 -> inst_valid=1, inst_illegal=1, c_inst_flag=1, inst_pc=0.
